// File: rtl/mtr_drv.sv
// Dual H-bridge PWM motor driver: shared free-running counter, per-wheel direction FSM.
// Optional deadband on direction reversal via `define MTR_DRV_DEADBAND_EN.

module mtr_drv_wheel #(
  parameter int unsigned PWM_W = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              bnd,
  input  logic [PWM_W-1:0]  cnt,
  input  logic signed [11:0] spd,
  output logic              fwd_pwm,
  output logic              rev_pwm
);

  localparam int unsigned MAG_MAX = (2 ** PWM_W) - 1;

  typedef enum logic [1:0] {IDLE, FWD, REV, DEAD} st_t;

  st_t              st;
  st_t              st_bnd;
  logic [PWM_W-1:0] mag;
  logic             dir;
  logic [12:0]      spd_abs;
  logic [PWM_W-1:0] spd_mag;

  // Saturated magnitude and boundary-time state decision from the live speed
  always_comb begin
    spd_abs = spd[11] ? (13'd0 - {spd[11], spd}) : {1'b0, spd};
    spd_mag = (32'(spd_abs) > MAG_MAX) ? PWM_W'(MAG_MAX) : PWM_W'(spd_abs);
    if (spd == 12'sd0) begin
      st_bnd = IDLE;
    end else begin
      st_bnd = spd[11] ? REV : FWD;
`ifdef MTR_DRV_DEADBAND_EN
      if ((st == FWD && spd[11]) || (st == REV && !spd[11])) begin
        st_bnd = DEAD;
      end
`endif
    end
  end

  // Boundary sampling uses the freshly decided state so the cnt==0 compare belongs to the new period
  always_ff @(posedge clk) begin
    if (rst) begin
      st      <= IDLE;
      mag     <= '0;
      dir     <= 1'b0;
      fwd_pwm <= 1'b0;
      rev_pwm <= 1'b0;
    end else if (!en) begin
      st      <= IDLE;
      fwd_pwm <= 1'b0;
      rev_pwm <= 1'b0;
    end else if (bnd) begin
      st      <= st_bnd;
      mag     <= spd_mag;
      dir     <= spd[11];
      fwd_pwm <= (st_bnd == FWD) && !spd[11] && (cnt < spd_mag);
      rev_pwm <= (st_bnd == REV) &&  spd[11] && (cnt < spd_mag);
    end else begin
      fwd_pwm <= (st == FWD) && !dir && (cnt < mag);
      rev_pwm <= (st == REV) &&  dir && (cnt < mag);
    end
  end

endmodule

module mtr_drv #(
  parameter int unsigned PWM_W = 11
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic signed [11:0] lft_spd,
  input  logic signed [11:0] rght_spd,
  output logic               lft_fwd_pwm,
  output logic               lft_rev_pwm,
  output logic               rght_fwd_pwm,
  output logic               rght_rev_pwm,
  output logic               pwm_synch
);

  logic [PWM_W-1:0] cnt;
  logic             bnd;

  assign bnd = (cnt == '0);

  // Period counter; pwm_synch is registered so it is high exactly while cnt==0
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      pwm_synch <= 1'b1;
    end else begin
      cnt       <= cnt + PWM_W'(1);
      pwm_synch <= &cnt;
    end
  end

  mtr_drv_wheel #(.PWM_W(PWM_W)) u_lft (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .bnd     (bnd),
    .cnt     (cnt),
    .spd     (lft_spd),
    .fwd_pwm (lft_fwd_pwm),
    .rev_pwm (lft_rev_pwm)
  );

  mtr_drv_wheel #(.PWM_W(PWM_W)) u_rght (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .bnd     (bnd),
    .cnt     (cnt),
    .spd     (rght_spd),
    .fwd_pwm (rght_fwd_pwm),
    .rev_pwm (rght_rev_pwm)
  );

endmodule

// File: tb/tb_mtr_drv.sv
// Self-checking bench for mtr_drv: directed period-level scenarios plus random stimulus
// compared every clock against a behavioural model.

module tb_mtr_drv;

  localparam int P    = 2048;
  localparam int MAXM = P - 1;
`ifdef MTR_DRV_DEADBAND_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic               en;
  logic signed [11:0] ls, rs;
  logic               lf, lr, rf, rr, sync;

  int total = 0;
  int bad   = 0;

  // model: mode 0 idle, 1 forward, 2 reverse, 3 dead
  int m_cnt;
  int m_mode [2];
  int m_mag  [2];
  logic [4:0] exp_v;

  int c_lf, c_lr, c_rf, c_rr, c_sync;

  always #5 clk = ~clk;

  mtr_drv #(.PWM_W(11)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .lft_spd      (ls),
    .rght_spd     (rs),
    .lft_fwd_pwm  (lf),
    .lft_rev_pwm  (lr),
    .rght_fwd_pwm (rf),
    .rght_rev_pwm (rr),
    .pwm_synch    (sync)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Predicts the outputs after the coming edge from the inputs currently applied
  task automatic model_step();
    int s, a, want;
    logic [1:0] f, r;
    f = '0;
    r = '0;
    if (rst) begin
      m_cnt = 0;
      for (int w = 0; w < 2; w++) begin
        m_mode[w] = 0;
        m_mag[w]  = 0;
      end
      exp_v = 5'b10000;
    end else begin
      for (int w = 0; w < 2; w++) begin
        s = (w == 0) ? ls : rs;
        if (!en) begin
          m_mode[w] = 0;
        end else if (m_cnt == 0) begin
          if (s == 0) begin
            m_mode[w] = 0;
          end else begin
            want = (s > 0) ? 1 : 2;
            if ((m_mode[w] == 1 || m_mode[w] == 2) && m_mode[w] != want)
              m_mode[w] = DB ? 3 : want;
            else
              m_mode[w] = want;
          end
          a = (s < 0) ? -s : s;
          m_mag[w] = (a > MAXM) ? MAXM : a;
        end
        f[w] = en && (m_mode[w] == 1) && (m_cnt < m_mag[w]);
        r[w] = en && (m_mode[w] == 2) && (m_cnt < m_mag[w]);
      end
      m_cnt = (m_cnt + 1) % P;
      exp_v = {m_cnt == 0, f[0], r[0], f[1], r[1]};
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    chk("cycle", {27'd0, sync, lf, lr, rf, rr}, {27'd0, exp_v});
    chk("legs_exclusive", {30'd0, lf & lr, rf & rr}, 32'd0);
    c_lf   += int'(lf);
    c_lr   += int'(lr);
    c_rf   += int'(rf);
    c_rr   += int'(rr);
    c_sync += int'(sync);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clr();
    c_lf = 0; c_lr = 0; c_rf = 0; c_rr = 0; c_sync = 0;
  endtask

  // Step until the next edge is a period boundary
  task automatic align();
    int k;
    k = 0;
    while (m_cnt != 0 && k <= P) begin
      step();
      k++;
    end
    chk("align_bound", {31'd0, k > P}, 32'd0);
  endtask

  function automatic logic signed [11:0] rnd_spd();
    case ($urandom_range(0, 5))
      0:       return 12'sd0;
      1:       return -12'sd2048;
      2:       return 12'sd2047;
      default: return 12'($urandom);
    endcase
  endfunction

  initial begin
    rst = 1'b1; en = 1'b1; ls = 12'sd0; rs = 12'sd0;
    m_cnt = 0;
    for (int w = 0; w < 2; w++) begin m_mode[w] = 0; m_mag[w] = 0; end
    run(3);
    chk("reset_outputs", {28'd0, lf, lr, rf, rr}, 32'd0);
    chk("reset_synch", {31'd0, sync}, 32'd1);
    rst = 1'b0;

    // forward drive and saturation
    ls = 12'sd512; rs = -12'sd2048;
    align();
    for (int p = 0; p < 2; p++) begin
      clr(); run(P);
      chk("fwd512_lf", c_lf, 512);
      chk("fwd512_lr", c_lr, 0);
      chk("sat_rr", c_rr, 2047);
      chk("sat_rf", c_rf, 0);
      chk("synch_per_period", c_sync, 1);
    end

    // reversal +300 -> -300 mid-period
    ls = 12'sd300;
    clr(); run(P);
    chk("rev_pre_lf", c_lf, 300);
    clr(); run(1000); ls = -12'sd300; run(P - 1000);
    chk("rev_finish_lf", c_lf, 300);
    chk("rev_finish_lr", c_lr, 0);
    clr(); run(P);
    chk("rev_next_lf", c_lf, 0);
    chk("rev_next_lr", c_lr, DB ? 0 : 300);
    clr(); run(P);
    chk("rev_after_lr", c_lr, 300);

    // enable drop at cnt=100
    ls = 12'sd1000;
    clr(); run(P);
    clr(); run(100);
    en = 1'b0;
    run(1);
    chk("en_off_outputs", {28'd0, lf, lr, rf, rr}, 32'd0);
    clr(); run(2 * P);
    chk("en_off_synch", c_sync, 2);
    chk("en_off_drive", c_lf + c_lr + c_rf + c_rr, 0);
    en = 1'b1;
    clr(); align();
    chk("en_wait_boundary", c_lf + c_rr, 0);
    clr(); run(P);
    chk("en_resume_lf", c_lf, 1000);
    chk("en_resume_rr", c_rr, 2047);

    // reset pulsed at cnt=700
    run(700);
    rst = 1'b1;
    run(1);
    chk("rst_mid_outputs", {28'd0, lf, lr, rf, rr}, 32'd0);
    chk("rst_mid_synch", {31'd0, sync}, 32'd1);
    rst = 1'b0;
    clr(); run(P);
    chk("rst_resume_lf", c_lf, 1000);

    // random stimulus
    for (int i = 0; i < 12 * P; i++) begin
      if ($urandom_range(0, 399) == 0) ls = rnd_spd();
      if ($urandom_range(0, 399) == 0) rs = rnd_spd();
      if ($urandom_range(0, 1499) == 0) en = ~en;
      rst = ($urandom_range(0, 5999) == 0);
      step();
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mtr_drv.md
MTR_DRV -- requirements
Module: mtr_drv

Interface
REQ-001 The block SHALL have parameter PWM_W, default 11, meaning the PWM counter width in bits; the period is 2^PWM_W clocks.
REQ-002 The block SHALL have port clk, input, 1 bit, the system clock; all logic is on the rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, a synchronous active-high reset.
REQ-004 The block SHALL have port en, input, 1 bit, the drive enable (pwr_up); when low, all outputs are forced low.
REQ-005 The block SHALL have port lft_spd, input, 12 bits signed, the left wheel speed command (two's complement).
REQ-006 The block SHALL have port rght_spd, input, 12 bits signed, the right wheel speed command.
REQ-007 The block SHALL have port lft_fwd_pwm, output, 1 bit, the left H-bridge forward leg.
REQ-008 The block SHALL have port lft_rev_pwm, output, 1 bit, the left H-bridge reverse leg.
REQ-009 The block SHALL have port rght_fwd_pwm, output, 1 bit, the right H-bridge forward leg.
REQ-010 The block SHALL have port rght_rev_pwm, output, 1 bit, the right H-bridge reverse leg.
REQ-011 The block SHALL have port pwm_synch, output, 1 bit, a one-clock pulse at the start of each period.

Function
REQ-012 The block SHALL implement cnt as a free-running PWM_W-bit counter that increments every clock and wraps from 2^PWM_W-1 to 0.
REQ-013 pwm_synch SHALL be high for exactly the one clock in which cnt==0.
REQ-014 Each wheel SHALL sample its speed only when cnt==0 (period boundary), so mid-period speed changes have no effect until the next boundary.
REQ-015 At sampling, magnitude SHALL be |spd| saturated to 2^PWM_W-1 (for example, -2048 maps to 2047), and direction SHALL be the sign bit.
REQ-016 Each wheel SHALL have an FSM with states IDLE, FWD, REV and DEAD, evaluated at the boundary:
- Speed of 0 goes to IDLE.
- From IDLE, a positive speed goes to FWD and a negative speed goes to REV.
- FWD with a negative speed, or REV with a positive speed, goes to DEAD.
- DEAD always lasts exactly one period, then goes to FWD, REV or IDLE according to the speed sampled at the next boundary.
REQ-017 In FWD, the forward leg SHALL be high while cnt < latched magnitude, and the reverse leg SHALL be low.
REQ-018 REV SHALL mirror FWD, driving the reverse leg instead of the forward leg.
REQ-019 In IDLE and DEAD, both legs SHALL be low.
REQ-020 The PWM outputs SHALL be registered, so an output reflects the cnt comparison with one clock of latency.
REQ-021 A wheel's forward and reverse legs SHALL never be high in the same clock, in any state, under any input sequence.
REQ-022 When en is low, every FSM SHALL go to IDLE on the next clock (without waiting for a boundary) and all PWM outputs SHALL be low; cnt and pwm_synch keep running.
REQ-023 When en rises, a wheel SHALL leave IDLE only at the next boundary.
REQ-024 The left and right wheels SHALL operate independently but share cnt and pwm_synch.

Reset
REQ-025 While rst is high at a clock edge, the block SHALL clear cnt to 0, set both FSMs to IDLE, clear latched magnitudes and directions to 0, and drive all PWM outputs low.
REQ-026 pwm_synch SHALL be asserted during the first clock after rst is released, because cnt==0.
REQ-027 A reset asserted mid-period SHALL take priority over en and over every FSM transition.

Configuration
REQ-028 With macro MTR_DRV_DEADBAND_EN defined, a direction reversal SHALL pass through DEAD for one full period as specified in REQ-016.
REQ-029 Without MTR_DRV_DEADBAND_EN, DEAD SHALL be unreachable and a reversal SHALL switch FWD to REV (or REV to FWD) directly at the boundary; REQ-021 still holds.

Verification
REQ-030 Forward drive: PWM_W=11, en=1, lft_spd=+512 held for 2 periods -> lft_fwd_pwm high for 512 clocks per 2048-clock period and lft_rev_pwm always low.
REQ-031 Saturation: rght_spd=-2048 -> rght_rev_pwm high for 2047 of every 2048 clocks and rght_fwd_pwm always low.
REQ-032 Reversal with the macro: lft_spd steps from +300 to -300 mid-period -> the current period finishes at 300, then one period with both legs low, then lft_rev_pwm high for 300 clocks per period.
REQ-033 Reversal without the macro: the same stimulus as REQ-032 -> lft_rev_pwm is high for 300 clocks in the period immediately after the boundary.
REQ-034 Enable drop: en deasserted at cnt=100 with spd=+1000 -> all outputs low by the next clock, pwm_synch continues every 2048 clocks, and drive resumes only at the first boundary after en returns high.
REQ-035 Reset mid-operation: rst pulsed at cnt=700 -> the next clock shows all outputs low, and pwm_synch is high in the first clock after rst is released.
